// File: rtl/axi_memory_mock_pkg.sv
// Shared definitions for the AXI4-Lite memory mock: bus widths, response
// codes, default memory depth, channel state encodings and the byte-strobe
// merge helper used on every write.
package axi_memory_mock_pkg;

    localparam int AXI_ADDR_W       = 32;
    localparam int AXI_DATA_W       = 32;
    localparam int AXI_STRB_W       = 4;
    localparam int MEMORY_NUM_WORDS = 1024;
    localparam int BYTES_PER_WORD   = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'b00,
        RD_ACCEPT = 2'b01,
        RD_RESP   = 2'b10
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'b00,
        WR_ACCEPT = 2'b01,
        WR_RESP   = 2'b10
    } wr_state_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [AXI_DATA_W-1:0] apply_strobe(
        input logic [AXI_DATA_W-1:0] old_word,
        input logic [AXI_DATA_W-1:0] new_word,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < AXI_STRB_W; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_memory_mock.sv
// AXI4-Lite slave backed by two word arrays: i_data (based at 0) and d_data
// (based at DMEM_BASE). Both arrays live at this level so benches can
// preload and inspect them by hierarchical name; they are never reset.
//
// Optional feature macro: AXI_MEM_MOCK_BOUNDS_CHECK_EN
//   defined   - addresses outside both regions answer SLVERR, read data 0,
//               writes are dropped.
//   undefined - addr[31] picks d_data (1) or i_data (0), the word index
//               wraps modulo MEM_WORDS, every response is OKAY.
module axi_memory_mock
    import axi_memory_mock_pkg::*;
#(
    parameter int          MEM_WORDS = MEMORY_NUM_WORDS,
    parameter logic [31:0] DMEM_BASE = 32'h0000_1000
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    // write address channel
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [AXI_ADDR_W-1:0] S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    // write data channel
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    input  logic [AXI_DATA_W-1:0] S_AXI_WDATA,
    input  logic [AXI_STRB_W-1:0] S_AXI_WSTRB,
    // write response channel
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    output logic [1:0]            S_AXI_BRESP,
    // read address channel
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    input  logic [AXI_ADDR_W-1:0] S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    // read data channel
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [AXI_DATA_W-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP
);

    localparam int IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int BYTE_SHIFT = $clog2(BYTES_PER_WORD);

    // Storage; intentionally outside any reset so preloads survive RSTn.
    logic [AXI_DATA_W-1:0] i_data [0:MEM_WORDS-1];
    logic [AXI_DATA_W-1:0] d_data [0:MEM_WORDS-1];

    // Channel state and registered outputs.
    rd_state_t             rd_state_r;
    wr_state_t             wr_state_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic [AXI_DATA_W-1:0] rdata_r;
    logic [1:0]            rresp_r;
    logic                  awready_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;

    // Decoded addresses: {error, select_d_data, word_index}.
    logic [IDX_W+1:0]      rd_dec_s;
    logic [IDX_W+1:0]      wr_dec_s;
    logic                  rd_err_s;
    logic                  rd_sel_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic                  wr_err_s;
    logic                  wr_sel_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic                  wr_fire_s;
    logic                  unused_s;

    // Map a byte address to {error, region select, word index}.
    function automatic logic [IDX_W+1:0] decode(input logic [AXI_ADDR_W-1:0] addr);
        logic             err;
        logic             sel;
        logic [IDX_W-1:0] idx;
`ifdef AXI_MEM_MOCK_BOUNDS_CHECK_EN
        logic [31:0] region_bytes;
        region_bytes = 32'(MEM_WORDS * BYTES_PER_WORD);
        if (addr < region_bytes) begin
            err = 1'b0;
            sel = 1'b0;
            idx = IDX_W'(addr >> BYTE_SHIFT);
        end else if ((addr >= DMEM_BASE) && ((addr - DMEM_BASE) < region_bytes)) begin
            err = 1'b0;
            sel = 1'b1;
            idx = IDX_W'((addr - DMEM_BASE) >> BYTE_SHIFT);
        end else begin
            err = 1'b1;
            sel = 1'b0;
            idx = {IDX_W{1'b0}};
        end
`else
        err = 1'b0;
        sel = addr[31];
        idx = IDX_W'((addr >> BYTE_SHIFT) % 32'(MEM_WORDS));
`endif
        return {err, sel, idx};
    endfunction

    assign rd_dec_s = decode(S_AXI_ARADDR);
    assign wr_dec_s = decode(S_AXI_AWADDR);
    assign rd_err_s = rd_dec_s[IDX_W+1];
    assign rd_sel_s = rd_dec_s[IDX_W];
    assign rd_idx_s = rd_dec_s[IDX_W-1:0];
    assign wr_err_s = wr_dec_s[IDX_W+1];
    assign wr_sel_s = wr_dec_s[IDX_W];
    assign wr_idx_s = wr_dec_s[IDX_W-1:0];

    // The write lands on the edge where both READYs meet both VALIDs.
    assign wr_fire_s = (wr_state_r == WR_ACCEPT) && S_AXI_AWVALID && S_AXI_WVALID;

    // Protection bits carry no meaning here; the base only matters when bounds checking.
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, DMEM_BASE};

    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = awready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;

    // Read channel FSM: one-cycle ARREADY pulse, then hold RVALID/RDATA until RREADY.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_state_r <= RD_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            rresp_r    <= RESP_OKAY;
        end else begin
            case (rd_state_r)
                RD_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        arready_r  <= 1'b1;
                        rd_state_r <= RD_ACCEPT;
                    end
                end
                RD_ACCEPT: begin
                    arready_r <= 1'b0;
                    if (S_AXI_ARVALID) begin
                        rvalid_r   <= 1'b1;
                        rresp_r    <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
                        // Sampled before any same-edge write commits, so a
                        // colliding read sees the old word.
                        rdata_r    <= rd_err_s ? 32'h0000_0000 :
                                      (rd_sel_s ? d_data[rd_idx_s] : i_data[rd_idx_s]);
                        rd_state_r <= RD_RESP;
                    end else begin
                        rd_state_r <= RD_IDLE;
                    end
                end
                RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        rvalid_r   <= 1'b0;
                        rd_state_r <= RD_IDLE;
                    end
                end
                default: begin
                    rd_state_r <= RD_IDLE;
                    arready_r  <= 1'b0;
                    rvalid_r   <= 1'b0;
                    rdata_r    <= 32'h0000_0000;
                    rresp_r    <= RESP_OKAY;
                end
            endcase
        end
    end

    // Write channel FSM: wait for AW and W together, pulse both READYs, hold BVALID until BREADY.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_state_r <= WR_IDLE;
            awready_r  <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
        end else begin
            case (wr_state_r)
                WR_IDLE: begin
                    if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        awready_r  <= 1'b1;
                        wr_state_r <= WR_ACCEPT;
                    end
                end
                WR_ACCEPT: begin
                    awready_r <= 1'b0;
                    if (wr_fire_s) begin
                        bvalid_r   <= 1'b1;
                        bresp_r    <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
                        wr_state_r <= WR_RESP;
                    end else begin
                        wr_state_r <= WR_IDLE;
                    end
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_r   <= 1'b0;
                        wr_state_r <= WR_IDLE;
                    end
                end
                default: begin
                    wr_state_r <= WR_IDLE;
                    awready_r  <= 1'b0;
                    bvalid_r   <= 1'b0;
                    bresp_r    <= RESP_OKAY;
                end
            endcase
        end
    end

    // Array update: strobed byte merge into whichever region the write decodes to.
    always_ff @(posedge CLK) begin
        if (wr_fire_s && !wr_err_s) begin
            if (wr_sel_s) begin
                d_data[wr_idx_s] <= apply_strobe(d_data[wr_idx_s], S_AXI_WDATA, S_AXI_WSTRB);
            end else begin
                i_data[wr_idx_s] <= apply_strobe(i_data[wr_idx_s], S_AXI_WDATA, S_AXI_WSTRB);
            end
        end
    end

endmodule

// File: tb/tb_axi_memory_mock.sv
// Directed self-checking bench for axi_memory_mock. The data-region address
// used for d_data accesses depends on AXI_MEM_MOCK_BOUNDS_CHECK_EN: DMEM_BASE
// when bounds checking is on, 32'h8000_0000 (addr[31] selects d_data) when off.
module tb_axi_memory_mock;

`ifdef AXI_MEM_MOCK_BOUNDS_CHECK_EN
    localparam logic [31:0] D_ADDR = 32'h0000_1000;
`else
    localparam logic [31:0] D_ADDR = 32'h8000_0000;
`endif

    logic        CLK;
    logic        RSTn;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;

    int tests_run    = 0;
    int tests_failed = 0;

    axi_memory_mock #(
        .MEM_WORDS (1024),
        .DMEM_BASE (32'h0000_1000)
    ) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP)
    );

    // 100 MHz clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        n = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        tick();
        while (!S_AXI_ARREADY && n < 20) begin
            tick();
            n++;
        end
        if (!S_AXI_ARREADY) check("ar_timeout", 32'(S_AXI_ARREADY), 32'd1);
        tick();
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin
            tick();
            n++;
        end
        if (!S_AXI_RVALID) check("r_timeout", 32'(S_AXI_RVALID), 32'd1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        n = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        while (!S_AXI_AWREADY && n < 20) begin
            tick();
            n++;
        end
        if (!S_AXI_AWREADY) check("aw_timeout", 32'(S_AXI_AWREADY), 32'd1);
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin
            tick();
            n++;
        end
        if (!S_AXI_BVALID) check("b_timeout", 32'(S_AXI_BVALID), 32'd1);
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;

        RSTn          = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_AWADDR  = 32'h0;
        S_AXI_AWPROT  = 3'b000;
        S_AXI_WVALID  = 1'b0;
        S_AXI_WDATA   = 32'h0;
        S_AXI_WSTRB   = 4'h0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_ARADDR  = 32'h0;
        S_AXI_ARPROT  = 3'b000;
        S_AXI_RREADY  = 1'b0;

        dut.d_data[0] = 32'hDEAD_BEEF;
        dut.d_data[1] = 32'h0000_0000;
        dut.d_data[2] = 32'h0000_0000;
        dut.d_data[3] = 32'h0101_0101;
        dut.d_data[4] = 32'h0000_0000;
        dut.i_data[0] = 32'hA5A5_0001;
        dut.i_data[4] = 32'hFFFF_FFFF;

        repeat (3) tick();
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_wready",  32'(S_AXI_WREADY),  32'd0);
        check("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check("rst_rdata",   S_AXI_RDATA,        32'h0);
        check("rst_rresp",   32'(S_AXI_RRESP),   32'd0);
        check("rst_bresp",   32'(S_AXI_BRESP),   32'd0);
        RSTn = 1'b1;
        tick();

        // Preloaded read with exact handshake timing.
        S_AXI_ARADDR  = D_ADDR;
        S_AXI_ARVALID = 1'b1;
        tick();
        check("rd0_arready", 32'(S_AXI_ARREADY), 32'd1);
        check("rd0_rvalid_early", 32'(S_AXI_RVALID), 32'd0);
        tick();
        S_AXI_ARVALID = 1'b0;
        check("rd0_arready_drop", 32'(S_AXI_ARREADY), 32'd0);
        check("rd0_rvalid", 32'(S_AXI_RVALID), 32'd1);
        check("rd0_rdata",  S_AXI_RDATA, 32'hDEAD_BEEF);
        check("rd0_rresp",  32'(S_AXI_RRESP), 32'd0);
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        check("rd0_rvalid_done", 32'(S_AXI_RVALID), 32'd0);

        // Partial-strobe write with exact handshake timing.
        S_AXI_AWADDR  = D_ADDR + 32'd4;
        S_AXI_WDATA   = 32'h1122_3344;
        S_AXI_WSTRB   = 4'b0101;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        check("wr1_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("wr1_wready",  32'(S_AXI_WREADY),  32'd1);
        check("wr1_bvalid_early", 32'(S_AXI_BVALID), 32'd0);
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("wr1_awready_drop", 32'(S_AXI_AWREADY), 32'd0);
        check("wr1_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("wr1_bresp",  32'(S_AXI_BRESP),  32'd0);
        check("wr1_mem",    dut.d_data[1], 32'h0022_0044);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("wr1_bvalid_done", 32'(S_AXI_BVALID), 32'd0);

        // Read of address 0 with RREADY held low; a new AR must not be taken meanwhile.
        S_AXI_ARADDR  = 32'h0;
        S_AXI_ARVALID = 1'b1;
        tick();
        tick();
        S_AXI_ARADDR = 32'h4;
        check("stall_rvalid0", 32'(S_AXI_RVALID), 32'd1);
        check("stall_rdata0",  S_AXI_RDATA, 32'hA5A5_0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rvalid",  32'(S_AXI_RVALID),  32'd1);
            check("stall_rdata",   S_AXI_RDATA,        32'hA5A5_0001);
            check("stall_arready", 32'(S_AXI_ARREADY), 32'd0);
        end
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        check("stall_rvalid_done", 32'(S_AXI_RVALID), 32'd0);

        // AW alone must wait for W.
        S_AXI_AWADDR  = D_ADDR + 32'd8;
        S_AXI_WDATA   = 32'hCAFE_F00D;
        S_AXI_WSTRB   = 4'b1111;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("awonly_awready", 32'(S_AXI_AWREADY), 32'd0);
            check("awonly_wready",  32'(S_AXI_WREADY),  32'd0);
        end
        S_AXI_WVALID = 1'b1;
        tick();
        check("awonly_awready_go", 32'(S_AXI_AWREADY), 32'd1);
        check("awonly_wready_go",  32'(S_AXI_WREADY),  32'd1);
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("awonly_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("awonly_mem",    dut.d_data[2], 32'hCAFE_F00D);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;

        // Instruction-region write with upper-byte strobes, then a zero-strobe write.
        axi_write(32'h0000_0010, 32'hAABB_CCDD, 4'b1010, rsp);
        check("iwr_bresp", 32'(rsp), 32'd0);
        axi_read(32'h0000_0010, rd, rsp);
        check("iwr_rdata", rd, 32'hAAFF_CCFF);
        axi_write(32'h0000_0010, 32'h1234_5678, 4'b0000, rsp);
        check("zstrb_bresp", 32'(rsp), 32'd0);
        axi_read(32'h0000_0010, rd, rsp);
        check("zstrb_rdata", rd, 32'hAAFF_CCFF);

        // Read and write of the same word accepted on the same edge.
        S_AXI_ARADDR  = D_ADDR + 32'd12;
        S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR  = D_ADDR + 32'd12;
        S_AXI_WDATA   = 32'h0202_0202;
        S_AXI_WSTRB   = 4'b1111;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        check("both_arready", 32'(S_AXI_ARREADY), 32'd1);
        check("both_awready", 32'(S_AXI_AWREADY), 32'd1);
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("both_rvalid", 32'(S_AXI_RVALID), 32'd1);
        check("both_rdata_old", S_AXI_RDATA, 32'h0101_0101);
        check("both_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("both_mem_new", dut.d_data[3], 32'h0202_0202);
        S_AXI_RREADY = 1'b1;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        S_AXI_BREADY = 1'b0;
        check("both_rvalid_done", 32'(S_AXI_RVALID), 32'd0);
        check("both_bvalid_done", 32'(S_AXI_BVALID), 32'd0);

        // Reset while a write response is pending.
        S_AXI_AWADDR  = D_ADDR + 32'd16;
        S_AXI_WDATA   = 32'h55AA_55AA;
        S_AXI_WSTRB   = 4'b1111;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("prerst_bvalid", 32'(S_AXI_BVALID), 32'd1);
        RSTn = 1'b0;
        #1;
        check("inrst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check("inrst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("inrst_mem4",    dut.d_data[4], 32'h55AA_55AA);
        check("inrst_mem0",    dut.d_data[0], 32'hDEAD_BEEF);
        tick();
        check("inrst_bvalid_hold", 32'(S_AXI_BVALID), 32'd0);
        RSTn = 1'b1;
        tick();
        axi_read(D_ADDR, rd, rsp);
        check("postrst_rdata", rd, 32'hDEAD_BEEF);
        check("postrst_rresp", 32'(rsp), 32'd0);

`ifdef AXI_MEM_MOCK_BOUNDS_CHECK_EN
        axi_read(32'h0000_8000, rd, rsp);
        check("oob_rresp", 32'(rsp), 32'd2);
        check("oob_rdata", rd, 32'h0);
        axi_write(32'h0000_8000, 32'hFFFF_FFFF, 4'b1111, rsp);
        check("oob_bresp", 32'(rsp), 32'd2);
        check("oob_mem_i0", dut.i_data[0], 32'hA5A5_0001);
`else
        // addr[31]=0 selects i_data; word 0x400 wraps to index 0.
        axi_read(32'h0000_1000, rd, rsp);
        check("wrap_rdata", rd, 32'hA5A5_0001);
        check("wrap_rresp", 32'(rsp), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi_memory_mock.md
AXI_MEMORY_MOCK -- requirements
Module: axi_memory_mock

Interface
REQ-001 Parameter MEM_WORDS, default 1024, sets the number of 32-bit words in each of the instruction and data arrays.
REQ-002 Parameter DMEM_BASE, default 32'h0000_1000, is the byte base address of the data region; the instruction region base is 0.
REQ-003 CLK  in  1  single clock; all logic on rising edge.
REQ-004 RSTn  in  1  asynchronous, active-low reset.
REQ-005 S_AXI_AWVALID/AWREADY  in/out  1/1  write-address handshake; S_AXI_AWADDR  in  32; S_AXI_AWPROT  in  3, ignored.
REQ-006 S_AXI_WVALID/WREADY  in/out  1/1  write-data handshake; S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4  byte enables.
REQ-007 S_AXI_BVALID/BREADY  out/in  1/1  write-response handshake; S_AXI_BRESP  out  2.
REQ-008 S_AXI_ARVALID/ARREADY  in/out  1/1  read-address handshake; S_AXI_ARADDR  in  32; S_AXI_ARPROT  in  3, ignored.
REQ-009 S_AXI_RVALID/RREADY  out/in  1/1  read-data handshake; S_AXI_RDATA  out  32; S_AXI_RRESP  out  2.
REQ-010 Storage arrays SHALL be named i_data[0:MEM_WORDS-1] and d_data[0:MEM_WORDS-1], 32 bits wide, at the top level of the module, so benches can preload and inspect them hierarchically.

Function
REQ-011 Address decode: addr in [0, 4*MEM_WORDS) selects i_data; addr in [DMEM_BASE, DMEM_BASE+4*MEM_WORDS) selects d_data; word index = (addr - base) >> 2; addr[1:0] is ignored.
REQ-012 Read: when ARVALID=1 and no read response is pending, ARREADY pulses high for one cycle; in the next cycle RVALID=1 with RDATA = the selected word and RRESP=OKAY (2'b00).
REQ-013 RVALID, RDATA and RRESP SHALL hold stable until RREADY=1; ARREADY SHALL stay low while RVALID=1.
REQ-014 Write: when AWVALID=1, WVALID=1 and no write response is pending, AWREADY and WREADY pulse high together for one cycle; the strobed bytes are written on that edge.
REQ-015 BVALID=1 with BRESP=OKAY in the cycle after the write is accepted; held until BREADY=1; AW/W stay not-ready while BVALID=1.
REQ-016 Only bytes with WSTRB[i]=1 update bits [8i+7:8i]; WSTRB=0 leaves the word unchanged but still returns a response.
REQ-017 Writes to the i_data region SHALL be performed identically to d_data writes.
REQ-018 The read and write channels are independent; a read and a write accepted in the same cycle SHALL both complete, and a same-word read returns the pre-write value.
REQ-019 An AW or W presented alone SHALL NOT be accepted until its partner is also valid.

Reset
REQ-020 While RSTn=0: AWREADY, WREADY, ARREADY, BVALID and RVALID = 0; BRESP and RRESP = 2'b00; RDATA = 0; any pending response is discarded.
REQ-021 Reset SHALL NOT clear i_data or d_data; preloaded contents survive reset.

Configuration
REQ-022 With AXI_MEM_MOCK_BOUNDS_CHECK_EN defined, an address outside both regions returns SLVERR (2'b10), RDATA=0 for reads, and no array update for writes.
REQ-023 Without AXI_MEM_MOCK_BOUNDS_CHECK_EN, addr bit 31 selects d_data (1) or i_data (0), the word index is taken modulo MEM_WORDS, and all responses are OKAY.

Structure
REQ-024 The shared package SHALL hold the AXI address/data/strobe widths (32/32/4), the response codes OKAY=2'b00 and SLVERR=2'b10, MEMORY_NUM_WORDS, and BYTES_PER_WORD=4.
REQ-025 The module SHALL contain no sub-module; both arrays stay in this module to preserve the hierarchical names in REQ-010.

Verification
REQ-026 Preload d_data[0]=32'hDEADBEEF, then read DMEM_BASE -> ARREADY pulse, and one cycle later RVALID=1, RDATA=32'hDEADBEEF, RRESP=OKAY.
REQ-027 Write 32'h11223344 with WSTRB=4'b0101 to DMEM_BASE+4 over 0 -> d_data[1]=32'h00220044 and BVALID=1 one cycle after acceptance.
REQ-028 Hold RREADY=0 for 3 cycles after a read of address 0 -> RVALID and RDATA stay stable and ARREADY stays 0; RREADY=1 then completes the transfer.
REQ-029 AWVALID=1 with WVALID=0 for 2 cycles -> AWREADY remains 0; assert WVALID -> both READY signals pulse and the write completes.
REQ-030 Assert RSTn=0 while BVALID=1 -> BVALID=0 immediately with memory contents intact; with AXI_MEM_MOCK_BOUNDS_CHECK_EN defined, a read of 32'h0000_8000 -> RRESP=2'b10, RDATA=0.
